// File: rtl/kxk_systolic_conv_stream.sv
// kxk_systolic_conv_stream: streamed KxK valid-mode convolution with filter reuse, backpressure and saturation
module kxk_systolic_conv_stream #(
  parameter int DATA_W = 8,
  parameter int IMG    = 4,
  parameter int K      = 3,
  parameter int OUT_W  = 8,
  parameter int SAT    = 1,
  parameter int ACC_W  = 2*DATA_W+$clog2(K*K)+1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              keep_f,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int N  = IMG-K+1;
  localparam int KK = K*K;
  localparam int II = IMG*IMG;
  localparam int CW = II > 1 ? $clog2(II) : 1;
  localparam int RW = N > 1 ? $clog2(N) : 1;
  localparam int PW = 2*DATA_W;
  typedef enum logic [1:0] {IDLE, LOAD_F, LOAD_I, COMPUTE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] f [KK];
  logic [DATA_W-1:0] img [II];
  logic [RW-1:0] r, c;
  logic fin, v1, last1, stall, xfer, win_last, fire;
  logic [PW-1:0] prod [KK];
  logic [ACC_W-1:0] acc;
  logic [OUT_W-1:0] res;
  assign in_ready = state == LOAD_F || state == LOAD_I;
  assign busy     = state != IDLE;
  assign xfer     = in_valid & in_ready;
  assign stall    = out_valid & ~out_ready;
  assign fire     = out_valid & out_ready & out_last;
  assign win_last = r == RW'(N-1) && c == RW'(N-1);
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = keep_f ? LOAD_I : LOAD_F;
      LOAD_F:  if (xfer && cnt == CW'(KK-1)) state_nx = LOAD_I;
      LOAD_I:  if (xfer && cnt == CW'(II-1)) state_nx = COMPUTE;
      COMPUTE: if (fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      done  <= state == COMPUTE && fire;
      if (xfer) cnt <= (state_nx != state) ? '0 : cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < KK; k++) f[k] <= '0;
      for (int k = 0; k < II; k++) img[k] <= '0;
    end else if (xfer) begin
      for (int k = 0; k < KK; k++) if (state == LOAD_F && cnt == CW'(k)) f[k] <= in_data;
      for (int k = 0; k < II; k++) if (state == LOAD_I && cnt == CW'(k)) img[k] <= in_data;
    end
  end
  always_comb begin
    acc = '0;
    for (int k = 0; k < KK; k++) acc = acc + ACC_W'(prod[k]);
  end
  assign res = (SAT != 0 && acc > ACC_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : acc[OUT_W-1:0];
  // Issue counter, product stage and output register all freeze together under backpressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r         <= '0;
      c         <= '0;
      fin       <= 1'b0;
      v1        <= 1'b0;
      last1     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      for (int k = 0; k < KK; k++) prod[k] <= '0;
    end else if (!stall) begin
      v1        <= state == COMPUTE && !fin;
      last1     <= win_last;
      out_valid <= v1;
      out_last  <= v1 & last1;
      out_data  <= res;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          prod[i*K+j] <= PW'(img[CW'((int'(r)+i)*IMG+int'(c)+j)]) * PW'(f[i*K+j]);
      if (state != COMPUTE) begin
        r   <= '0;
        c   <= '0;
        fin <= 1'b0;
      end else if (!fin) begin
        c <= (c == RW'(N-1)) ? '0 : c + 1'b1;
        if (c == RW'(N-1)) begin
          if (r == RW'(N-1)) fin <= 1'b1;
          else r <= r + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_kxk_systolic_conv_stream.sv
// tb_kxk_systolic_conv_stream: scoreboard bench over four builds sharing one input/output stream
module tb_kxk_systolic_conv_stream;
  logic clk = 0, rst = 0, keep_f = 0, in_valid = 0, out_ready = 1, bp = 0;
  logic [7:0] in_data = 0;
  logic [3:0] st = 0, ir, ov, ol, bz, dn;
  logic [3:0][7:0] od;
  logic [3:0] pst = 0;
  logic [3:0][7:0] pd;
  logic [10:0] q[$];
  logic [10:0] e;
  int checks = 0, errors = 0, ph = 0;
  int done_cnt[4] = '{default: 0};
  int f1[$] = '{1,5,8,6,0,7,3,1,2};
  int im1[$] = '{8,3,9,1,7,7,2,8,5,6,3,1,4,9,2,6};
  int f255[$], im255[$], f2[$], im2[$], f3[$], im3[$];
  always #5 clk = ~clk;

  kxk_systolic_conv_stream #(.IMG(4), .K(3), .SAT(1)) u0 (.clk(clk), .rst(rst), .start(st[0]), .keep_f(keep_f),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]), .out_data(od[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .out_last(ol[0]), .busy(bz[0]), .done(dn[0]));
  kxk_systolic_conv_stream #(.IMG(4), .K(3), .SAT(0)) u1 (.clk(clk), .rst(rst), .start(st[1]), .keep_f(keep_f),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]), .out_data(od[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .out_last(ol[1]), .busy(bz[1]), .done(dn[1]));
  kxk_systolic_conv_stream #(.IMG(5), .K(2), .SAT(1)) u2 (.clk(clk), .rst(rst), .start(st[2]), .keep_f(keep_f),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]), .out_data(od[2]), .out_valid(ov[2]),
    .out_ready(out_ready), .out_last(ol[2]), .busy(bz[2]), .done(dn[2]));
  kxk_systolic_conv_stream #(.IMG(3), .K(3), .SAT(1)) u3 (.clk(clk), .rst(rst), .start(st[3]), .keep_f(keep_f),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir[3]), .out_data(od[3]), .out_valid(ov[3]),
    .out_ready(out_ready), .out_last(ol[3]), .busy(bz[3]), .done(dn[3]));

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks hold-under-stall
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (dn[k]) done_cnt[k]++;
      if (rst && pst[k]) begin
        chk("stall_valid", int'(ov[k]), 1);
        chk("stall_data", int'(od[k]), int'(pd[k]));
      end
      if (ov[k] && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", q.size(), 1);
        else begin
          e = q.pop_front();
          chk("out_inst", k, int'(e[10:9]));
          chk("out_data", int'(od[k]), int'(e[7:0]));
          chk("out_last", int'(ol[k]), int'(e[8]));
        end
      end
      pst[k] = rst && ov[k] && !out_ready;
      pd[k] = od[k];
    end
  end

  // out_ready pattern 1,0,0,1,0,0,... while bp is set
  initial forever begin
    @(posedge clk); #1;
    if (bp) begin out_ready = (ph == 0); ph = (ph + 1) % 3; end
    else begin out_ready = 1; ph = 0; end
  end

  task automatic exp(int idx, int last, int d);
    q.push_back({2'(idx), 1'(last), 8'(d)});
  endtask

  task automatic exp4(int idx, int a, int b, int c, int d);
    exp(idx, 0, a); exp(idx, 0, b); exp(idx, 0, c); exp(idx, 1, d);
  endtask

  function automatic int conv(int n_img, int k, int f[$], int im[$], int r, int c);
    int a = 0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++) a += im[(r+i)*n_img+c+j] * f[i*k+j];
    return a > 255 ? 255 : a;
  endfunction

  task automatic send(int idx, int w);
    in_data = 8'(w);
    in_valid = 1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (ir[idx]) break;
      if (t > 100) begin chk("in_ready_timeout", int'(ir[idx]), 1); break; end
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic send_all(int idx, int w[$]);
    foreach (w[i]) begin
      if (i % 5 == 4) begin @(posedge clk); #1; end
      send(idx, w[i]);
    end
  endtask

  task automatic start_job(int idx, bit keep);
    st[idx] = 1;
    keep_f = keep;
    @(posedge clk); #1;
    st[idx] = 0;
    keep_f = 0;
    chk("busy_after_start", int'(bz[idx]), 1);
  endtask

  task automatic wait_done(int idx);
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk); #1;
      if (dn[idx]) break;
    end
    chk("done_seen", int'(dn[idx]), 1);
    chk("all_results_seen", q.size(), 0);
    q.delete();
  endtask

  initial begin
    for (int i = 0; i < 9; i++) f255.push_back(255);
    for (int i = 0; i < 16; i++) im255.push_back(255);
    f2 = '{3,7,2,9};
    for (int i = 0; i < 25; i++) im2.push_back((i*37+5) % 256);
    f3 = '{1,2,3,4,5,6,7,8,9};
    im3 = '{9,8,7,6,5,4,3,2,1};
    repeat (3) @(posedge clk); #1;
    chk("rst_flags", int'({ir, ov, ol, bz, dn}), 0);
    chk("rst_data", int'(od), 0);
    rst = 1;
    @(posedge clk); #1;
    // basic job
    start_job(0, 0); exp4(0, 178, 177, 134, 165);
    send_all(0, f1); send_all(0, im1);
    wait_done(0);
    // filter reuse, started in the done cycle
    start_job(0, 1); exp4(0, 178, 177, 134, 165);
    send_all(0, im1);
    @(negedge clk);
    chk("in_ready_after_img", int'(ir[0]), 0);
    wait_done(0);
    // backpressure
    bp = 1;
    start_job(0, 0); exp4(0, 178, 177, 134, 165);
    send_all(0, f1); send_all(0, im1);
    wait_done(0);
    bp = 0;
    // saturate / truncate
    start_job(0, 0); exp4(0, 255, 255, 255, 255);
    send_all(0, f255); send_all(0, im255);
    wait_done(0);
    start_job(1, 0); exp4(1, 9, 9, 9, 9);
    send_all(1, f255); send_all(1, im255);
    wait_done(1);
    // reset mid image load
    start_job(0, 0);
    send_all(0, f1);
    for (int i = 0; i < 7; i++) send(0, im1[i]);
    rst = 0;
    @(negedge clk);
    chk("midrst_flags", int'({ir, ov, ol, bz, dn}), 0);
    chk("midrst_data", int'(od), 0);
    repeat (2) @(posedge clk); #1;
    rst = 1;
    repeat (3) @(posedge clk); #1;
    chk("after_rst_idle", int'(bz), 0);
    start_job(0, 1); exp4(0, 0, 0, 0, 0);
    send_all(0, im1);
    wait_done(0);
    start_job(0, 0); exp4(0, 178, 177, 134, 165);
    send_all(0, f1); send_all(0, im1);
    wait_done(0);
    // IMG=5,K=2 against the model; IMG=K=3 single result
    start_job(2, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) exp(2, (r == 3 && c == 3), conv(5, 2, f2, im2, r, c));
    send_all(2, f2); send_all(2, im2);
    wait_done(2);
    start_job(3, 0); exp(3, 1, 165);
    send_all(3, f3); send_all(3, im3);
    wait_done(3);
    repeat (3) @(posedge clk);
    chk("done_cnt0", done_cnt[0], 6);
    chk("done_cnt1", done_cnt[1], 1);
    chk("done_cnt2", done_cnt[2], 1);
    chk("done_cnt3", done_cnt[3], 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
